// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, instruction
// types/opcodes, datapath select codes and the decoder result bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_IF    = 3'b001,
    S_ID    = 3'b010,
    S_EX    = 3'b011,
    S_MEM   = 3'b100,
    S_WB    = 3'b101,
    S_FAULT = 3'b110
  } state_e;

  typedef enum logic [1:0] {
    T_R = 2'b00,
    T_I = 2'b01,
    T_J = 2'b10,
    T_S = 2'b11
  } itype_e;

  localparam logic [4:0] OPR_AND  = 5'd0, OPR_ADD  = 5'd1, OPR_SUB = 5'd2, OPR_CMP = 5'd3;
  localparam logic [4:0] OPI_ANDI = 5'd0, OPI_ADDI = 5'd1, OPI_LW  = 5'd2, OPI_SW  = 5'd3,
                         OPI_BEQ  = 5'd4;
  localparam logic [4:0] OPJ_J    = 5'd0, OPJ_JAL  = 5'd1;
  localparam logic [4:0] OPS_SLL  = 5'd0, OPS_SLR  = 5'd1, OPS_SLLV = 5'd2, OPS_SLRV = 5'd3;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_SLL = 3'b011, ALU_SLR = 3'b100;
  localparam logic [1:0] SRC_IMM = 2'b00, SRC_REG = 2'b01, SRC_SHAMT = 2'b10;
  localparam logic [1:0] PC_INC = 2'b00, PC_BTA = 2'b01, PC_JA = 2'b10, PC_RA = 2'b11;

  // State in which an instruction retires.
  typedef enum logic [1:0] {
    LC_ID  = 2'b00,
    LC_EX  = 2'b01,
    LC_MEM = 2'b10,
    LC_WB  = 2'b11
  } last_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       ext_op;
    logic       reg_src;
    logic       wb_src;
    logic       mem;
    logic       store;
    logic       jal;
    logic       beq;
    logic       illegal;
    last_e      last;
  } dec_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational decode of the latched instruction type/opcode into the
// datapath controls and the retire-state class.
module mc_decoder
  import mc_pkg::*;
(
  input  logic [1:0] type_i,
  input  logic [4:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.ext_op = 1'b1;
    dec_o.last   = LC_WB;
    case (type_i)
      T_R: begin
        dec_o.alu_src = SRC_REG;
        case (op_i)
          OPR_AND: dec_o.alu_op = ALU_AND;
          OPR_ADD: dec_o.alu_op = ALU_ADD;
          OPR_SUB: dec_o.alu_op = ALU_SUB;
          OPR_CMP: begin dec_o.alu_op = ALU_SUB; dec_o.last = LC_EX; end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      T_I: begin
        dec_o.alu_src = SRC_IMM;
        case (op_i)
          OPI_ANDI: begin dec_o.alu_op = ALU_AND; dec_o.ext_op = 1'b0; end
          OPI_ADDI: dec_o.alu_op = ALU_ADD;
          OPI_LW:   begin dec_o.alu_op = ALU_ADD; dec_o.mem = 1'b1; dec_o.wb_src = 1'b1; end
          OPI_SW: begin
            dec_o.alu_op  = ALU_ADD;
            dec_o.reg_src = 1'b1;
            dec_o.mem     = 1'b1;
            dec_o.store   = 1'b1;
            dec_o.last    = LC_MEM;
          end
          OPI_BEQ: begin
            dec_o.alu_op  = ALU_SUB;
            dec_o.reg_src = 1'b1;
            dec_o.beq     = 1'b1;
            dec_o.last    = LC_EX;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      T_J: begin
        dec_o.last = LC_ID;
        case (op_i)
          OPJ_J:   dec_o.jal = 1'b0;
          OPJ_JAL: dec_o.jal = 1'b1;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      default: begin
        case (op_i)
          OPS_SLL:  begin dec_o.alu_op = ALU_SLL; dec_o.alu_src = SRC_SHAMT; end
          OPS_SLR:  begin dec_o.alu_op = ALU_SLR; dec_o.alu_src = SRC_SHAMT; end
          OPS_SLLV: begin dec_o.alu_op = ALU_SLL; dec_o.alu_src = SRC_REG; end
          OPS_SLRV: begin dec_o.alu_op = ALU_SLR; dec_o.alu_src = SRC_REG; end
          default:  dec_o.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: IF/ID/EX/MEM/WB flow with memory handshakes,
// return-stack depth tracking, handshake timeout and a sticky FAULT state.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DEPTH   = 16,
  localparam int DW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic [31:0]   ir_i,
  output logic          imem_req_o,
  input  logic          imem_ack_i,
  output logic          dmem_req_o,
  input  logic          dmem_ack_i,
  output logic          dmem_we_o,
  input  logic          zero_i,
  output logic          pc_write_o,
  output logic [1:0]    pc_src_o,
  output logic          ir_write_o,
  output logic          reg_write_o,
  output logic          flag_write_o,
  output logic          reg_src_o,
  output logic          ext_op_o,
  output logic          wb_src_o,
  output logic [1:0]    alu_src_o,
  output logic [2:0]    alu_op_o,
  output logic          stack_push_o,
  output logic          stack_pop_o,
  output logic [DW-1:0] depth_o,
  output logic [2:0]    state_o,
  output logic          instr_done_o,
  output logic          fault_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST  = WW'(TIMEOUT - 1);
  localparam logic [DW-1:0] D_FULL   = DW'(DEPTH);
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [WW-1:0] W_ONE    = WW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [1:0]    type_q;
  logic [4:0]    op_q;
  logic          stop_q;
  logic          last_cyc;
  dec_t          dec;

  logic unused_ir;
  assign unused_ir = ^ir_i[26:3];

  mc_decoder u_dec (
    .type_i (type_q),
    .op_i   (op_q),
    .dec_o  (dec)
  );

  assign depth_o = depth_q;
  assign state_o = state_q;

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    wait_d       = wait_q;
    last_cyc     = 1'b0;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_INC;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    flag_write_o = 1'b0;
    reg_src_o    = 1'b0;
    ext_op_o     = 1'b0;
    wb_src_o     = 1'b0;
    alu_src_o    = SRC_IMM;
    alu_op_o     = ALU_ADD;
    stack_push_o = 1'b0;
    stack_pop_o  = 1'b0;
    instr_done_o = 1'b0;
    fault_o      = 1'b0;

    case (state_q)
      S_IDLE: if (run_i) state_d = S_IF;
      S_IF: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          wait_d     = '0;
          state_d    = S_ID;
        end else if (wait_q == TO_LAST) begin
          wait_d  = '0;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + W_ONE;
        end
      end
      S_ID: begin
        if (dec.illegal) begin
          state_d = S_FAULT;
        end else if (dec.last == LC_ID) begin
          if (dec.jal && depth_q == D_FULL) begin
            state_d = S_FAULT;
          end else begin
            pc_write_o   = 1'b1;
            pc_src_o     = PC_JA;
            stack_push_o = dec.jal;
            last_cyc     = 1'b1;
          end
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (dec.last == LC_EX) begin
          flag_write_o = 1'b1;
          if (dec.beq && zero_i) begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_BTA;
          end
          last_cyc = 1'b1;
        end else begin
          state_d = dec.mem ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec.store;
        if (dmem_ack_i) begin
          wait_d = '0;
          if (dec.last == LC_MEM) last_cyc = 1'b1;
          else                    state_d  = S_WB;
        end else if (wait_q == TO_LAST) begin
          wait_d  = '0;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + W_ONE;
        end
      end
      S_WB: begin
        reg_write_o = 1'b1;
        wb_src_o    = dec.wb_src;
        last_cyc    = 1'b1;
      end
      S_FAULT: fault_o = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Datapath selects stay stable from EX until the instruction retires.
    if (state_q inside {S_EX, S_MEM, S_WB}) begin
      alu_op_o  = dec.alu_op;
      alu_src_o = dec.alu_src;
      ext_op_o  = dec.ext_op;
      reg_src_o = dec.reg_src;
    end

    // Return via stop bit wins over a taken branch; popping an empty stack faults.
    if (last_cyc) begin
      if (stop_q && type_q != T_J) begin
        if (depth_q == '0) begin
          pc_write_o = 1'b0;
          pc_src_o   = PC_INC;
          state_d    = S_FAULT;
        end else begin
          stack_pop_o  = 1'b1;
          pc_write_o   = 1'b1;
          pc_src_o     = PC_RA;
          depth_d      = depth_q - D_ONE;
          instr_done_o = 1'b1;
          state_d      = run_i ? S_IF : S_IDLE;
        end
      end else begin
        instr_done_o = 1'b1;
        state_d      = run_i ? S_IF : S_IDLE;
      end
    end

    if (stack_push_o) depth_d = depth_q + D_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      wait_q  <= '0;
      type_q  <= '0;
      op_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      wait_q  <= wait_d;
      if (ir_write_o) begin
        type_q <= ir_i[2:1];
        op_q   <= ir_i[31:27];
        stop_q <= ir_i[0];
      end
    end
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the 32-bit RISC datapath. It drives the per-state control strobes for PC, IR, register file, ALU, data memory and return-address stack. It runs the IF→ID→EX→MEM→WB flow per instruction type, using req/ack handshakes to instruction and data memory. It tracks return-stack depth and enters a sticky FAULT on illegal opcodes, stack over/underflow or memory timeout.

## Interface
- TIMEOUT, 255, maximum consecutive req cycles without ack before FAULT (≥1)
- DEPTH, 16, return-stack capacity in entries
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- run  in  1  enable; sampled in IDLE and at end of each instruction
- ir  in  32  instruction word from instruction memory; captured on ir_write
- imem_req / imem_ack  out / in  1  instruction fetch handshake
- dmem_req / dmem_ack  out / in  1  data access handshake; dmem_we out 1, 1 = store
- zero  in  1  ALU zero result, valid in EX
- pc_write  out  1  load PC; pc_src out 2: 00 PC+1, 01 BTA, 10 JA, 11 RA
- ir_write, reg_write, flag_write, reg_src, ext_op, wb_src  out  1 each
- alu_src  out  2  00 ext immediate, 01 reg B, 10 shamt
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 SLL, 100 SLR
- stack_push, stack_pop  out  1  return-stack strobes
- depth  out  clog2(DEPTH+1)  current stack occupancy
- state  out  3  current state; instr_done out 1 one-cycle pulse; fault out 1 sticky

## Operation
- **Reset and fault outputs.** Reset gives state=IDLE, depth=0, counters=0, and every output 0. FAULT drives all strobes to 0 with fault=1 until reset.
- **Field latching.** Fields are latched from ir on the ir_write edge: type=ir[2:1], opcode=ir[31:27], stop=ir[0].
- **Type codes.** 00 R (AND,ADD,SUB,CMP = 0..3); 01 I (ANDI,ADDI,LW,SW,BEQ = 0..4); 10 J (J,JAL = 0..1); 11 S (SLL,SLR,SLLV,SLRV = 0..3). An opcode outside its range → FAULT from ID.
- **IDLE.** run=1 → IF.
- **IF.** imem_req=1 until imem_ack. On the ack cycle: ir_write=1, pc_write=1, pc_src=00 → ID.
- **ID, J-type.** pc_write=1, pc_src=10. JAL also asserts stack_push. Next is end-of-instruction; the stop bit is ignored for J-type.
- **ID, other types.** → EX.
- **EX, ALU mapping.** alu_op: AND/ANDI→AND; ADD/ADDI/LW/SW→ADD; SUB/CMP/BEQ→SUB; SLL/SLLV→SLL; SLR/SLRV→SLR.
- **EX, source mapping.** alu_src: I-type→00; R-type, SLLV, SLRV→01; SLL, SLR→10. ext_op=1 except ANDI. reg_src=1 for SW and BEQ.
- **Hold.** alu_op, alu_src, ext_op and reg_src are held through MEM/WB.
- **EX, compare/branch.** CMP and BEQ assert flag_write and end the instruction. BEQ with zero=1 asserts pc_write, pc_src=01.
- **EX, next state.** LW/SW → MEM; all others → WB.
- **MEM.** dmem_req=1 (dmem_we=1 for SW) until dmem_ack. On ack: LW → WB; SW ends the instruction.
- **WB.** reg_write=1 for one cycle; wb_src=1 for LW, else 0. The instruction ends.
- **End of instruction.** The last cycle asserts instr_done. Next state is IF if run=1, else IDLE.
- **Stop bit.** With stop=1 (non-J), the last cycle also asserts stack_pop, pc_write, pc_src=11. This overrides a taken BEQ in the same cycle.
- **Stack depth.** Push increments depth; pop decrements it.
- **Stack overflow.** Push at depth=DEPTH → FAULT, no push, no pc_write.
- **Stack underflow.** Pop at depth=0 → FAULT, no pop, no pc_write, no instr_done.
- **Timeout.** The wait counter increments each req cycle without ack and clears on ack. An ack in cycle TIMEOUT is accepted; no ack by the end of cycle TIMEOUT → FAULT.
- **Async reset.** Asserting reset in any state, including mid-handshake, returns to IDLE immediately and drops req.

## Timing
- State register, depth and wait counter are registered. Outputs are combinational from state, latched fields, depth and the current ack/zero inputs.
- Ack may arrive in the first req cycle, giving zero-wait operation.
- Zero-wait instruction latency in cycles: J/JAL 2, CMP/BEQ 3, R/S/ANDI/ADDI/SW 4, LW 5. Each wait cycle adds 1.
- req stays asserted through the ack cycle and drops the next cycle.
- instr_done is exactly 1 cycle per retired instruction.

## Structure
- Package mc_pkg holds:
  - state encoding: IDLE 000, IF 001, ID 010, EX 011, MEM 100, WB 101, FAULT 110
  - type and opcode constants
  - alu_op, alu_src and pc_src codes
- Sub-module mc_decoder: combinational decode of the latched type/opcode into alu_op, alu_src, ext_op, reg_src, wb_src, illegal, last-state class.

## Test plan
- **ADD, zero-wait.** run=1, ADD (type 00, op 1), acks in first req cycle → IF,ID,EX,WB over 4 cycles; reg_write=1 in WB with alu_op=000, alu_src=01; instr_done in cycle 4.
- **LW, waits.** LW with dmem_ack after 3 wait cycles → MEM lasts 4 cycles with dmem_we=0, then WB with wb_src=1; total 8 cycles.
- **BEQ taken.** BEQ with zero=1 → in EX: flag_write=1, pc_write=1, pc_src=01, alu_op=001; next state IF.
- **JAL then return.** JAL → stack_push in ID, depth 0→1. Then ADDI with stop=1 → WB cycle has stack_pop, pc_src=11; depth returns to 0.
- **Stack faults.** 16 consecutive JALs, then a 17th → FAULT with fault=1 and depth=16. Separately, stop=1 at depth 0 → FAULT with no pc_write.
- **Timeout and illegal.** TIMEOUT=4, imem_ack never asserted → FAULT after 4 req cycles, imem_req=0 afterwards. Illegal opcode (type 00, op 7) → FAULT from ID. Reset in either case → IDLE with all outputs 0.
